// File: rtl/pkt_commit_fifo.sv
// pkt_commit_fifo: packet FIFO; a word becomes readable only once the eod word of its packet is written.
// Latency: read data 1 cycle after an accepted read; afull/aempty lag the pointers by 1 cycle.
// Backpressure: full blocks writes; with PKT_COMMIT_FIFO_DROP_EN an aborted or overflowing packet is dropped whole.
// The read data port is named do_o because "do" is a reserved word.
module pkt_commit_fifo #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 14,
  parameter int AEMPTY_CNT = 1500,
  parameter int AFULL_CNT  = 16000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] di,
  input  logic              we,
  input  logic              eod_in,
  input  logic              abort,
  output logic              full,
  output logic              afull,
  input  logic              re,
  output logic [DATA_W-1:0] do_o,
  output logic              eod_out,
  output logic              dvalid,
  output logic              empty,
  output logic              aempty,
  output logic [ADDR_W:0]   pkt_cnt,
  output logic              pkt_dropped
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_CNT);
  localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_CNT);
  localparam logic [PW-1:0] ONE      = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [DATA_W-1:0] do_q;
  logic              eod_q;
  logic              dvalid_q;
  logic              afull_q;
  logic              aempty_q;

  // Each entry holds {eod, data}
  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] rd_word;

  logic [PW-1:0] occ;      // all stored words, committed or not
  logic [PW-1:0] cmt_cnt;  // committed words still unread
  logic          wr_acc;
  logic          drop;
  logic          commit;
  logic          rd_acc;

  assign occ     = wptr_q - rptr_q;
  assign cmt_cnt = cptr_q - rptr_q;
  assign full    = (occ == DEPTH_V);
  assign empty   = (rptr_q == cptr_q);
  assign rd_word = mem[rptr_q[ADDR_W-1:0]];
  assign rd_acc  = re && !empty;
  assign commit  = wr_acc && eod_in;

  // Write-state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write-state transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wr_acc && !eod_in) state_d = S_OPEN;
      end
`ifdef PKT_COMMIT_FIFO_DROP_EN
      S_OPEN: begin
        if (abort)                 state_d = S_IDLE;
        else if (we && full)       state_d = S_DISCARD;
        else if (wr_acc && eod_in) state_d = S_IDLE;
      end
      S_DISCARD: begin
        if (we && eod_in) state_d = S_IDLE;
      end
`else
      S_OPEN: begin
        if (wr_acc && eod_in) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Write-state outputs: whether the word is stored and whether the open packet is dropped
  always_comb begin
    wr_acc = 1'b0;
    drop   = 1'b0;
`ifdef PKT_COMMIT_FIFO_DROP_EN
    case (state_q)
      S_IDLE: wr_acc = we && !full;
      S_OPEN: begin
        // abort wins over a same-cycle write; that word is lost with the packet
        if (abort || (we && full)) drop = 1'b1;
        else                       wr_acc = we && !full;
      end
      default: ;
    endcase
`else
    // Without drop support a write into a full FIFO simply loses the word
    wr_acc = we && !full;
`endif
  end

`ifndef PKT_COMMIT_FIFO_DROP_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  // Pointer and packet-count next state
  always_comb begin
    wptr_d    = wptr_q;
    cptr_d    = cptr_q;
    rptr_d    = rptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (drop) begin
      wptr_d = cptr_q;
    end else if (wr_acc) begin
      wptr_d = wptr_q + ONE;
      if (eod_in) cptr_d = wptr_q + ONE;
    end
    if (rd_acc) rptr_d = rptr_q + ONE;
    // A commit and an eod-read in the same cycle cancel out
    case ({commit, rd_acc && rd_word[DATA_W]})
      2'b10:   pkt_cnt_d = pkt_cnt_q + ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Storage array; not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q[ADDR_W-1:0]] <= {eod_in, di};
  end

  // Pointers, read output register and registered level flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      cptr_q    <= '0;
      rptr_q    <= '0;
      pkt_cnt_q <= '0;
      do_q      <= '0;
      eod_q     <= 1'b0;
      dvalid_q  <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
    end else begin
      wptr_q    <= wptr_d;
      cptr_q    <= cptr_d;
      rptr_q    <= rptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      dvalid_q  <= rd_acc;
      if (rd_acc) begin
        do_q  <= rd_word[DATA_W-1:0];
        eod_q <= rd_word[DATA_W];
      end
      afull_q  <= (occ > AFULL_V);
      aempty_q <= (cmt_cnt < AEMPTY_V);
    end
  end

`ifdef PKT_COMMIT_FIFO_DROP_EN
  logic drop_q;

  // One-cycle pulse per dropped packet
  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop;
  end

  assign pkt_dropped = drop_q;
`else
  assign pkt_dropped = 1'b0;
`endif

  assign do_o    = do_q;
  assign eod_out = eod_q;
  assign dvalid  = dvalid_q;
  assign afull   = afull_q;
  assign aempty  = aempty_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: doc/pkt_commit_fifo.md
PKT_COMMIT_FIFO -- requirements
Module: pkt_commit_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width per word.
REQ-002 SHALL have parameter ADDR_W, default 14: log2 depth; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter AEMPTY_CNT, default 1500: almost-empty threshold in committed words.
REQ-004 SHALL have parameter AFULL_CNT, default 16000: almost-full threshold in occupied words.
REQ-005 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous and active-high.
- di  in  DATA_W  write data.
- we  in  1  write request.
- eod_in  in  1  marks the written word as the last word of its packet.
- abort  in  1  discard the open (uncommitted) packet.
- full  out  1  no free word.
- afull  out  1  occupancy above AFULL_CNT.
- re  in  1  read request.
- do  out  DATA_W  read data.
- eod_out  out  1  eod marker of the word on do.
- dvalid  out  1  do/eod_out valid this cycle.
- empty  out  1  no committed word readable.
- aempty  out  1  committed words below AEMPTY_CNT.
- pkt_cnt  out  ADDR_W+1  number of complete packets stored.
- pkt_dropped  out  1  one-cycle pulse per discarded packet.

Function
REQ-006 SHALL keep three ADDR_W+1-bit pointers: wptr (write), cptr (commit), rptr (read); the MSB is the wrap bit.
REQ-007 SHALL accept a write when we=1 and full=0; word {di,eod_in} is stored at wptr, and wptr increments.
REQ-008 SHALL on an accepted write with eod_in=1 set cptr to the new wptr value on the same edge, and increment pkt_cnt.
REQ-009 SHALL assert full combinationally when wptr-rptr == DEPTH, and assert empty combinationally when rptr == cptr; uncommitted words are never readable.
REQ-010 SHALL accept a read when re=1 and empty=0; do and eod_out SHALL update on the next edge with dvalid=1, giving 1-cycle latency; dvalid=0 otherwise and do holds its value.
REQ-011 SHALL decrement pkt_cnt when an accepted read has a stored eod=1; a simultaneous commit and eod-read SHALL leave pkt_cnt unchanged.
REQ-012 SHALL register the flags: afull <= (wptr-rptr) > AFULL_CNT; aempty <= (cptr-rptr) < AEMPTY_CNT. Both SHALL be 1 cycle behind the pointers.
REQ-013 SHALL use write-state machine IDLE (wptr==cptr), OPEN (packet partly written) and DISCARD (dropping the remainder of the packet).
REQ-014 Transitions SHALL be:
- IDLE->OPEN on an accepted write with eod_in=0.
- OPEN->IDLE on an accepted write with eod_in=1, or on abort.
- OPEN->DISCARD on we=1 with full=1.
- DISCARD->IDLE on we=1 with eod_in=1.
REQ-015 SHALL make all writes in DISCARD non-accepting; wptr does not move.
REQ-016 Abort in OPEN SHALL set wptr<=cptr and pulse pkt_dropped; abort takes priority over a write in the same cycle, and that word is discarded. Abort in IDLE or DISCARD SHALL have no effect and no pulse.
REQ-017 OPEN->DISCARD SHALL set wptr<=cptr and pulse pkt_dropped once. we with full=1 in IDLE SHALL be ignored without a pulse.
REQ-018 Reads SHALL proceed independently of the write state; pointer differences are computed modulo 2**(ADDR_W+1).

Reset
REQ-019 On rst=1 at a clk edge, SHALL set the following; RAM contents are not cleared:
- wptr, cptr, rptr = 0; state = IDLE; pkt_cnt = 0.
- do = 0, eod_out = 0, dvalid = 0, pkt_dropped = 0.
- afull = 0, aempty = 1; full = 0 and empty = 1 follow from the pointers.
REQ-020 Reset mid-packet or mid-read SHALL discard all stored and open data with no pkt_dropped pulse.

Configuration
REQ-021 SHALL compile abort/overflow-drop support only when macro PKT_COMMIT_FIFO_DROP_EN is defined. Without the macro:
- abort is ignored; there is no DISCARD state and pkt_dropped is tied 0.
- we with full=1 silently loses that word and the packet stays OPEN.
- commit on eod is unchanged.

Verification (DATA_W=8, ADDR_W=4, AFULL_CNT=12, AEMPTY_CNT=4)
REQ-022 Write 0x10..0x12, eod on 0x12 -> empty falls the cycle after the 3rd write; pkt_cnt=1; reads return 0x10,0x11,0x12 with 1-cycle latency, eod_out=1 on 0x12, then pkt_cnt=0 and empty=1.
REQ-023 Write 5 words without eod -> empty stays 1 and afull=0; then abort -> pkt_dropped pulses once; wptr returns to 0; a following 2-word packet reads back intact.
REQ-024 With DROP_EN, write 16 words without eod, then 3 more, the last with eod -> full at 16; one pkt_dropped pulse; pkt_cnt=0; FIFO returns to empty/IDLE; the next packet is accepted.
REQ-025 Commit a 1-word packet and read an eod word in the same cycle with pkt_cnt=1 -> pkt_cnt stays 1.
REQ-026 Fill to 13 committed words -> afull=1 one cycle later; drain to 3 -> aempty=1; repeat across pointer wrap (rptr=14 start) with identical results.
REQ-027 Assert rst with 6 words stored and a packet OPEN -> every output reaches its reset value on the next edge; no pkt_dropped pulse.
